// File: rtl/mod_div_engine.sv
// rtl/mod_div_engine.sv - binary extended-Euclid modular divider, o_result = i_a * i_b^-1 mod i_n
//
// Responder side of the start/finished modular-arithmetic handshake. One
// shift/subtract step per clock in RUN; a watchdog bounds the RUN phase.
//
// Optional feature macro: DIV_ZERO_DET_EN
//    defined   : o_error port exists; b == 0 is caught in LOAD, watchdog expiry flags o_error
//    undefined : no o_error port; b == 0 ends through the watchdog with result 0
//
// Ports:
//    clk        clock
//    rst        asynchronous active-low reset
//    i_start    request pulse, accepted in IDLE and DONE only
//    i_n        modulus (odd, > 2), sampled on an accepted start
//    i_a        dividend (< i_n), sampled on an accepted start
//    i_b        divisor (< i_n), sampled on an accepted start
//    o_result   registered quotient, held until the next operation leaves RUN
//    o_finished single-cycle completion pulse (high in DONE)
//    o_busy     high in LOAD and RUN
//    o_error    divide-by-zero / watchdog flag (DIV_ZERO_DET_EN only)

`ifndef MAX_BITS
`define MAX_BITS 32
`endif

module mod_div_engine #(
   parameter int WIDTH     = `MAX_BITS,
   parameter int MAX_STEPS = 4*WIDTH+4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_n,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_finished,
   output logic             o_busy
`ifdef DIV_ZERO_DET_EN
   ,
   output logic             o_error
`endif
);

   localparam int CW = $clog2(MAX_STEPS+1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] u, v, n;
   logic [WIDTH:0]   x, y;          // one spare bit so x+n fits before halving
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   x_half, y_half, x_sub, y_sub, diff_xy, diff_yx;

   // Modular halving and subtraction on the coefficient registers. Both
   // stay in [0, n-1]: (x+n)>>1 < n, and a borrow out of the WIDTH+1-bit
   // difference (bit WIDTH set) means n must be added back.
   always_comb begin
      x_half  = x[0] ? ((x + {1'b0, n}) >> 1) : (x >> 1);
      y_half  = y[0] ? ((y + {1'b0, n}) >> 1) : (y >> 1);
      diff_xy = x - y;
      diff_yx = y - x;
      x_sub   = diff_xy[WIDTH] ? (diff_xy + {1'b0, n}) : diff_xy;
      y_sub   = diff_yx[WIDTH] ? (diff_yx + {1'b0, n}) : diff_yx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         u          <= '0;
         v          <= '0;
         n          <= '0;
         x          <= '0;
         y          <= '0;
         cnt        <= '0;
         o_result   <= '0;
         o_finished <= 1'b0;
         o_busy     <= 1'b0;
`ifdef DIV_ZERO_DET_EN
         o_error    <= 1'b0;
`endif
      end else begin
         o_finished <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // Accepting in DONE lets a sequencer chain o_result straight back in.
               if (i_start) begin
                  u      <= i_b;
                  v      <= i_n;
                  x      <= {1'b0, i_a};
                  y      <= '0;
                  n      <= i_n;
                  cnt    <= '0;
                  o_busy <= 1'b1;
`ifdef DIV_ZERO_DET_EN
                  o_error <= 1'b0;
`endif
                  state  <= LOAD;
               end else begin
                  state  <= IDLE;
               end
            end
            LOAD: begin
`ifdef DIV_ZERO_DET_EN
               if (u == '0) begin
                  o_result   <= '0;
                  o_error    <= 1'b1;
                  o_finished <= 1'b1;
                  o_busy     <= 1'b0;
                  state      <= DONE;
               end else begin
                  state      <= RUN;
               end
`else
               state <= RUN;
`endif
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (u == WIDTH'(1)) begin
                  o_result   <= x[WIDTH-1:0];
                  o_finished <= 1'b1;
                  o_busy     <= 1'b0;
                  state      <= DONE;
               end else if (v == WIDTH'(1)) begin
                  o_result   <= y[WIDTH-1:0];
                  o_finished <= 1'b1;
                  o_busy     <= 1'b0;
                  state      <= DONE;
               end else if (cnt == CW'(MAX_STEPS)) begin
                  o_result   <= '0;
                  o_finished <= 1'b1;
                  o_busy     <= 1'b0;
`ifdef DIV_ZERO_DET_EN
                  o_error    <= 1'b1;
`endif
                  state      <= DONE;
               end else if (!u[0]) begin
                  u <= u >> 1;
                  x <= x_half;
               end else if (!v[0]) begin
                  v <= v >> 1;
                  y <= y_half;
               end else if (u >= v) begin
                  u <= u - v;
                  x <= x_sub;
               end else begin
                  v <= v - u;
                  y <= y_sub;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_div_engine.sv
// tb/tb_mod_div_engine.sv - self-checking bench for mod_div_engine

module tb_mod_div_engine;

   localparam int W         = 32;
   localparam int MAX_STEPS = 4*W+4;
   localparam int LIMIT     = MAX_STEPS + 20;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         i_start = 1'b0;
   logic [W-1:0] i_n = '0, i_a = '0, i_b = '0;
   logic [W-1:0] o_result;
   logic         o_finished, o_busy;
`ifdef DIV_ZERO_DET_EN
   logic         o_error;
`endif

   int checks   = 0;
   int failures = 0;

   mod_div_engine #(.WIDTH(W), .MAX_STEPS(MAX_STEPS)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_n        (i_n),
      .i_a        (i_a),
      .i_b        (i_b),
      .o_result   (o_result),
      .o_finished (o_finished),
      .o_busy     (o_busy)
`ifdef DIV_ZERO_DET_EN
      ,
      .o_error    (o_error)
`endif
   );

   always #5 clk = ~clk;

   // Reference: ordinary division-based extended Euclid on 64-bit integers.
   function automatic longint ext_inv(input longint b, input longint n, output longint g);
      longint t, nt, r, nr, q, tmp;
      t = 0; nt = 1; r = n; nr = b;
      while (nr != 0) begin
         q   = r / nr;
         tmp = t - q*nt; t = nt; nt = tmp;
         tmp = r - q*nr; r = nr; nr = tmp;
      end
      g = r;
      if (t < 0) t = t + n;
      return t;
   endfunction

   function automatic longint unsigned ref_div(input longint unsigned a, input longint unsigned b,
                                               input longint unsigned n);
      longint g, inv;
      longint unsigned p;
      inv = ext_inv(longint'(b), longint'(n), g);
      p   = a * longint'(inv);
      return p % n;
   endfunction

   // Called at a negedge: present a request for the next posedge.
   task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] a, input logic [W-1:0] b);
      i_n = n; i_a = a; i_b = b; i_start = 1'b1;
   endtask

   // Counts posedges from the accepting edge until o_finished is seen.
   task automatic wait_done(output int lat, output bit to, output bit busy1);
      @(negedge clk);
      i_start = 1'b0;
      lat = 1;
      busy1 = o_busy;
      while (!o_finished && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      to = !o_finished;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (o_finished !== 1'b0) begin failures++; $display("FAIL reset_finished got=%b exp=0", o_finished); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      checks++; if (o_result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", o_result); end
`ifdef DIV_ZERO_DET_EN
      checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", o_error); end
`endif
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int lat; bit to, b1;
      start_op(7, 3, 5);
      wait_done(lat, to, b1);
      checks++; if (to) begin failures++; $display("FAIL basic_timeout got=no_finish exp=finish"); end
      checks++; if (o_result !== 32'd2) begin failures++; $display("FAIL basic_result got=%0d exp=2", o_result); end
      checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL basic_busy_load got=%b exp=1", b1); end
      @(negedge clk);
      checks++; if (o_finished !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", o_finished); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", o_busy); end
      checks++; if (o_result !== 32'd2) begin failures++; $display("FAIL basic_result_hold got=%0d exp=2", o_result); end
   endtask

   task automatic test_back_to_back;
      int lat; bit to, b1;
      start_op(7, 1, 3);
      wait_done(lat, to, b1);
      checks++; if (to || o_result !== 32'd5) begin failures++; $display("FAIL b2b_first got=%0d to=%b exp=5", o_result, to); end
      // Still in the finish cycle: chain the inverse straight back as the divisor.
      start_op(7, 4, o_result);
      wait_done(lat, to, b1);
      checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL b2b_no_gap got=%b exp=1", b1); end
      checks++; if (to || o_result !== 32'd5) begin failures++; $display("FAIL b2b_second got=%0d to=%b exp=5", o_result, to); end
      @(negedge clk);
   endtask

   task automatic test_half;
      int lat; bit to, b1;
      start_op(32'hFFFF_FFFB, 1, 2);
      wait_done(lat, to, b1);
      checks++; if (to || o_result !== 32'h7FFF_FFFE) begin failures++; $display("FAIL half_result got=%h to=%b exp=7ffffffe", o_result, to); end
      @(negedge clk);
   endtask

   task automatic test_b_one;
      int lat; bit to, b1;
      start_op(32'hFFFF_FFFB, 32'h1234_5678, 1);
      wait_done(lat, to, b1);
      checks++; if (to || o_result !== 32'h1234_5678) begin failures++; $display("FAIL bone_result got=%h exp=12345678", o_result); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL bone_latency got=%0d exp=3", lat); end
      @(negedge clk);
   endtask

   task automatic test_random;
      int lat; bit to, b1;
      longint unsigned n, a, b, expv, prod;
      longint g, inv;
      for (int i = 0; i < 25; i++) begin
         n = longint'(($urandom >> $urandom_range(0, 28)) | 32'd1);
         if (n < 3) n = 3;
         a = longint'($urandom) % (n - 1) + 1;
         do begin
            b   = longint'($urandom) % (n - 1) + 1;
            inv = ext_inv(longint'(b), longint'(n), g);
         end while (g != 1);
         expv = ref_div(a, b, n);
         start_op(W'(n), W'(a), W'(b));
         wait_done(lat, to, b1);
         checks++;
         if (to || longint'(o_result) != expv) begin
            failures++;
            $display("FAIL rand_result n=%0d a=%0d b=%0d got=%0d exp=%0d", n, a, b, o_result, expv);
         end
         prod = longint'(o_result) * b;
         checks++;
         if (prod % n != a) begin
            failures++;
            $display("FAIL rand_congruence n=%0d a=%0d b=%0d got=%0d exp=%0d", n, a, b, prod % n, a);
         end
         checks++;
         if (lat > 4*W+3) begin
            failures++;
            $display("FAIL rand_latency got=%0d exp<=%0d", lat, 4*W+3);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      int pulses = 0;
      start_op(32'hFFFF_FFFB, 1, 32'h0001_2345);
      @(negedge clk); i_start = 1'b0;     // LOAD
      repeat (6) @(negedge clk);          // five RUN steps done
      rst = 1'b0;
      #1;
      checks++; if (o_busy !== 1'b0 || o_finished !== 1'b0) begin failures++; $display("FAIL abort_ctrl got=busy%b/fin%b exp=0/0", o_busy, o_finished); end
      checks++; if (o_result !== '0) begin failures++; $display("FAIL abort_result got=%h exp=0", o_result); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (o_finished || o_busy) pulses++;
      end
      checks++; if (pulses != 0) begin failures++; $display("FAIL abort_no_pulse got=%0d exp=0", pulses); end
   endtask

   task automatic test_div_zero;
      int lat; bit to, b1;
      start_op(7, 3, 0);
      wait_done(lat, to, b1);
      checks++; if (to || o_result !== '0) begin failures++; $display("FAIL zero_result got=%h to=%b exp=0", o_result, to); end
`ifdef DIV_ZERO_DET_EN
      checks++; if (o_error !== 1'b1) begin failures++; $display("FAIL zero_error got=%b exp=1", o_error); end
      checks++; if (lat > 3) begin failures++; $display("FAIL zero_latency got=%0d exp<=3", lat); end
      start_op(7, 3, 5);
      wait_done(lat, to, b1);
      checks++; if (o_error !== 1'b0 || o_result !== 32'd2) begin failures++; $display("FAIL zero_clear got=err%b/%0d exp=0/2", o_error, o_result); end
`else
      checks++; if (lat !== MAX_STEPS+3) begin failures++; $display("FAIL zero_watchdog got=%0d exp=%0d", lat, MAX_STEPS+3); end
`endif
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_half;
      test_b_one;
      test_random;
      test_abort;
      test_div_zero;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
